mmu_reg_arb: RTL and testbench

- Arbitrates the single access port of the MMU register file between two requesters: the CPU PMOVE path (cpu_) and the table walker / fault logic (tw_).
- Serialises requests, sequences the one-cycle-latency read, and returns responses over valid/ready handshakes.
- Blocks CPU writes to translation-root/control registers (CRP, SRP, TC) while a table walk is in flight.
- Sits between the CPU-side MMU instruction decoder, the table walker, and the register file.

---
 rtl/mmu_reg_arb.sv | 165 ++++++++++++++++
 tb/tb_mmu_reg_arb.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_reg_arb.sv
// mmu_reg_arb: arbitrates the single MMU register-file port between the CPU
// PMOVE path and the table walker. One request is in flight at a time; reads
// take one extra cycle to capture the register-file output. CPU writes to
// CRP/SRP/TC are held off while a table walk is running.
module mmu_reg_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    input  logic                  cpu_rsp_ready,
    output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
    output logic                  cpu_rsp_err,

    input  logic                  tw_req_valid,
    output logic                  tw_req_ready,
    input  logic                  tw_req_we,
    input  logic [ADDR_WIDTH-1:0] tw_req_addr,
    input  logic [DATA_WIDTH-1:0] tw_req_wdata,
    output logic                  tw_rsp_valid,
    input  logic                  tw_rsp_ready,
    output logic [DATA_WIDTH-1:0] tw_rsp_rdata,
    output logic                  tw_rsp_err,

    input  logic                  walk_busy,

    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [DATA_WIDTH-1:0] reg_rd_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    state_t                  state;
    logic                    owner_tw;
    logic                    rr_tw;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic                    lat_err;

    logic                    cpu_eligible;
    logic                    tw_eligible;
    logic                    grant_cpu;
    logic                    grant_tw;
    logic                    addr_ok;
    logic                    rsp_pending;
    logic                    rsp_taken;

    // Eligibility, round-robin grant and the combinational request-ready path
    always_comb begin
        cpu_eligible  = cpu_req_valid &&
                        !(cpu_req_we && walk_busy && (cpu_req_addr <= ADDR_WIDTH'(2)));
        tw_eligible   = tw_req_valid;
        grant_cpu     = !rst && (state == IDLE) && cpu_eligible && (!tw_eligible || !rr_tw);
        grant_tw      = !rst && (state == IDLE) && tw_eligible && (!cpu_eligible || rr_tw);
        cpu_req_ready = grant_cpu;
        tw_req_ready  = grant_tw;
        addr_ok       = {1'b0, lat_addr} < (ADDR_WIDTH + 1)'(NUM_REGS);
        rsp_pending   = cpu_rsp_valid || tw_rsp_valid;
        rsp_taken     = owner_tw ? tw_rsp_ready : cpu_rsp_ready;
    end

    // Request sequencer: latch a grant, issue one strobe, capture read data, hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner_tw      <= 1'b0;
            rr_tw         <= 1'b0;
            lat_we        <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_err       <= 1'b0;
            reg_wr_en     <= 1'b0;
            reg_rd_en     <= 1'b0;
            reg_addr      <= '0;
            reg_wr_data   <= '0;
            cpu_rsp_valid <= 1'b0;
            cpu_rsp_rdata <= '0;
            cpu_rsp_err   <= 1'b0;
            tw_rsp_valid  <= 1'b0;
            tw_rsp_rdata  <= '0;
            tw_rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cpu || grant_tw) begin
                        owner_tw  <= grant_tw;
                        lat_we    <= grant_tw ? tw_req_we    : cpu_req_we;
                        lat_addr  <= grant_tw ? tw_req_addr  : cpu_req_addr;
                        lat_wdata <= grant_tw ? tw_req_wdata : cpu_req_wdata;
                        lat_err   <= 1'b0;
                        if (cpu_eligible && tw_eligible) begin
                            rr_tw <= !rr_tw;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (addr_ok) begin
                        reg_addr    <= lat_addr;
                        reg_wr_data <= lat_wdata;
                        reg_wr_en   <= lat_we;
                        reg_rd_en   <= !lat_we;
                        state       <= lat_we ? RESP : CAPT;
                    end else begin
                        lat_err <= 1'b1;
                        state   <= RESP;
                    end
                end
                CAPT: begin
                    if (reg_rd_en) begin
                        reg_rd_en <= 1'b0;
                    end else begin
                        if (owner_tw) begin
                            tw_rsp_valid  <= 1'b1;
                            tw_rsp_rdata  <= reg_rd_data;
                            tw_rsp_err    <= 1'b0;
                        end else begin
                            cpu_rsp_valid <= 1'b1;
                            cpu_rsp_rdata <= reg_rd_data;
                            cpu_rsp_err   <= 1'b0;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    reg_wr_en <= 1'b0;
                    reg_rd_en <= 1'b0;
                    if (!rsp_pending) begin
                        if (owner_tw) begin
                            tw_rsp_valid  <= 1'b1;
                            tw_rsp_rdata  <= '0;
                            tw_rsp_err    <= lat_err;
                        end else begin
                            cpu_rsp_valid <= 1'b1;
                            cpu_rsp_rdata <= '0;
                            cpu_rsp_err   <= lat_err;
                        end
                    end else if (rsp_taken) begin
                        cpu_rsp_valid <= 1'b0;
                        cpu_rsp_rdata <= '0;
                        cpu_rsp_err   <= 1'b0;
                        tw_rsp_valid  <= 1'b0;
                        tw_rsp_rdata  <= '0;
                        tw_rsp_err    <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_reg_arb.sv
// tb_mmu_reg_arb: directed scenarios for the MMU register-port arbiter with a
// small register-file model behind it. Unwritten registers read back as
// 32'hA5A5_00xx where xx is the address.
module tb_mmu_reg_arb;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic          cpu_rsp_valid, cpu_rsp_ready, cpu_rsp_err;
    logic [DW-1:0] cpu_rsp_rdata;
    logic          tw_req_valid, tw_req_ready, tw_req_we;
    logic [AW-1:0] tw_req_addr;
    logic [DW-1:0] tw_req_wdata;
    logic          tw_rsp_valid, tw_rsp_ready, tw_rsp_err;
    logic [DW-1:0] tw_rsp_rdata;
    logic          walk_busy;
    logic          reg_wr_en, reg_rd_en;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wr_data;
    logic [DW-1:0] reg_rd_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    int            wr_count      = 0;
    int            rd_count      = 0;
    int            overlap_count = 0;
    int            tw_hs_count   = 0;
    int            grant_idx     = 0;
    int            grant_log [32];
    logic [AW-1:0] last_wr_addr  = '0;
    logic [DW-1:0] last_wr_data  = '0;
    logic [DW-1:0] last_tw_rdata = '0;
    logic [DW-1:0] mem [16];
    logic [15:0]   written = 16'h0;

    mmu_reg_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(6)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
        .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
        .tw_req_valid(tw_req_valid), .tw_req_ready(tw_req_ready),
        .tw_req_we(tw_req_we), .tw_req_addr(tw_req_addr), .tw_req_wdata(tw_req_wdata),
        .tw_rsp_valid(tw_rsp_valid), .tw_rsp_ready(tw_rsp_ready),
        .tw_rsp_rdata(tw_rsp_rdata), .tw_rsp_err(tw_rsp_err),
        .walk_busy(walk_busy),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Register-file model plus strobe, grant and tw-handshake bookkeeping
    always @(posedge clk) begin
        if (reg_wr_en) begin
            wr_count          <= wr_count + 1;
            last_wr_addr      <= reg_addr;
            last_wr_data      <= reg_wr_data;
            mem[reg_addr]     <= reg_wr_data;
            written[reg_addr] <= 1'b1;
        end
        if (reg_rd_en) begin
            rd_count    <= rd_count + 1;
            reg_rd_data <= written[reg_addr] ? mem[reg_addr] : (32'hA5A5_0000 | 32'(reg_addr));
        end
        if (reg_wr_en && reg_rd_en) overlap_count <= overlap_count + 1;
        if (cpu_req_valid && cpu_req_ready && grant_idx < 32) begin
            grant_log[grant_idx] <= 0;
            grant_idx            <= grant_idx + 1;
        end else if (tw_req_valid && tw_req_ready && grant_idx < 32) begin
            grant_log[grant_idx] <= 1;
            grant_idx            <= grant_idx + 1;
        end
        if (tw_rsp_valid && tw_rsp_ready) begin
            tw_hs_count   <= tw_hs_count + 1;
            last_tw_rdata <= tw_rsp_rdata;
        end
    end

    // Hard stop in case the run wedges somewhere unexpected
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           output logic accepted, output int lat,
                           output logic [DW-1:0] rdata, output logic err);
        accepted      = 1'b0;
        lat           = -1;
        rdata         = '0;
        err           = 1'b0;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = data;
        cpu_req_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            #1;
            if (cpu_req_ready) accepted = 1'b1;
            tick();
        end
        cpu_req_valid = 1'b0;
        if (accepted) begin
            lat = 0;
            while (!cpu_rsp_valid && lat < 20) begin
                tick();
                lat++;
            end
            if (!cpu_rsp_valid) lat = -1;
            rdata = cpu_rsp_rdata;
            err   = cpu_rsp_err;
            cpu_rsp_ready = 1'b1;
            tick();
            cpu_rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        cpu_req_valid = 1'b1;
        #1;
        n_checks++;
        if (cpu_req_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ready_gated: got %b expected 0", cpu_req_ready);
        end
        cpu_req_valid = 1'b0;
        #1;
        n_checks++;
        if ({cpu_req_ready, tw_req_ready, cpu_rsp_valid, tw_rsp_valid, cpu_rsp_err, tw_rsp_err,
             reg_wr_en, reg_rd_en} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
                     {cpu_req_ready, tw_req_ready, cpu_rsp_valid, tw_rsp_valid, cpu_rsp_err,
                      tw_rsp_err, reg_wr_en, reg_rd_en});
        end
        n_checks++;
        if ({cpu_rsp_rdata, tw_rsp_rdata, reg_wr_data, reg_addr} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h %h %h %h expected all zero",
                     cpu_rsp_rdata, tw_rsp_rdata, reg_wr_data, reg_addr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic acc; int lat; logic [DW-1:0] rd; logic err; int wr0;
        wr0 = wr_count;
        cpu_txn(1'b1, 4'd0, 32'h1234_5678, acc, lat, rd, err);
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("[TB] FAIL write_accept: got %b expected 1", acc); end
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("[TB] FAIL write_latency: got %0d expected 2", lat); end
        n_checks++;
        if ({err, rd} !== 33'h0) begin n_fail++; $display("[TB] FAIL write_rsp: got err=%b rdata=%h expected 0/0", err, rd); end
        n_checks++;
        if (wr_count - wr0 !== 1) begin n_fail++; $display("[TB] FAIL write_strobes: got %0d expected 1", wr_count - wr0); end
        n_checks++;
        if ({last_wr_addr, last_wr_data} !== {4'd0, 32'h1234_5678}) begin
            n_fail++;
            $display("[TB] FAIL write_payload: got %h/%h expected 0/12345678", last_wr_addr, last_wr_data);
        end
        n_checks++;
        if (cpu_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL write_rsp_drop: got %b expected 0", cpu_rsp_valid); end
    endtask

    task automatic test_read();
        logic acc; int lat; logic [DW-1:0] rd; logic err; int wr0; int rd0;
        wr0 = wr_count;
        rd0 = rd_count;
        cpu_txn(1'b0, 4'd0, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("[TB] FAIL read_latency: got %0d expected 3", lat); end
        n_checks++;
        if (rd !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL read_data: got %h expected 12345678", rd); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL read_err: got %b expected 0", err); end
        n_checks++;
        if ({rd_count - rd0, wr_count - wr0} !== {32'sd1, 32'sd0}) begin
            n_fail++;
            $display("[TB] FAIL read_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", rd_count - rd0, wr_count - wr0);
        end
    endtask

    task automatic test_round_robin();
        int g0; int rd0; int hs0;
        g0  = grant_idx;
        rd0 = rd_count;
        hs0 = tw_hs_count;
        cpu_req_we = 1'b0; cpu_req_addr = 4'd5; cpu_req_valid = 1'b1;
        tw_req_we  = 1'b0; tw_req_addr  = 4'd5; tw_req_valid  = 1'b1;
        cpu_rsp_ready = 1'b1;
        tw_rsp_ready  = 1'b1;
        for (int i = 0; i < 100 && (grant_idx - g0) < 6; i++) tick();
        cpu_req_valid = 1'b0;
        tw_req_valid  = 1'b0;
        repeat (8) tick();
        cpu_rsp_ready = 1'b0;
        tw_rsp_ready  = 1'b0;
        n_checks++;
        if (grant_idx - g0 !== 6) begin n_fail++; $display("[TB] FAIL rr_grant_count: got %0d expected 6", grant_idx - g0); end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (grant_log[g0 + k] !== (k % 2)) begin
                n_fail++;
                $display("[TB] FAIL rr_order_%0d: got %0d expected %0d", k, grant_log[g0 + k], k % 2);
            end
        end
        n_checks++;
        if (rd_count - rd0 !== 6) begin n_fail++; $display("[TB] FAIL rr_reads: got %0d expected 6", rd_count - rd0); end
        n_checks++;
        if (overlap_count !== 0) begin n_fail++; $display("[TB] FAIL rr_overlap: got %0d expected 0", overlap_count); end
        n_checks++;
        if (tw_hs_count - hs0 !== 3) begin n_fail++; $display("[TB] FAIL rr_tw_rsps: got %0d expected 3", tw_hs_count - hs0); end
        n_checks++;
        if (last_tw_rdata !== 32'hA5A5_0005) begin n_fail++; $display("[TB] FAIL rr_tw_data: got %h expected a5a50005", last_tw_rdata); end
    endtask

    task automatic test_walk_busy();
        int wr0; int hs0; logic cpu_seen;
        wr0 = wr_count;
        hs0 = tw_hs_count;
        walk_busy = 1'b1;
        cpu_req_we = 1'b1; cpu_req_addr = 4'd2; cpu_req_wdata = 32'hCAFE_0002; cpu_req_valid = 1'b1;
        tw_req_we  = 1'b0; tw_req_addr  = 4'd3; tw_req_valid  = 1'b1;
        tw_rsp_ready  = 1'b1;
        cpu_rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({cpu_req_ready, tw_req_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL busy_grant: got cpu=%b tw=%b expected cpu=0 tw=1", cpu_req_ready, tw_req_ready);
        end
        tick();
        tw_req_valid = 1'b0;
        cpu_seen = 1'b0;
        repeat (6) begin
            if (cpu_req_ready) cpu_seen = 1'b1;
            tick();
        end
        n_checks++;
        if (cpu_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_cpu_blocked: got %b expected 0", cpu_seen); end
        n_checks++;
        if ({tw_hs_count - hs0, wr_count - wr0} !== {32'sd1, 32'sd0}) begin
            n_fail++;
            $display("[TB] FAIL busy_tw_served: got tw=%0d wr=%0d expected tw=1 wr=0", tw_hs_count - hs0, wr_count - wr0);
        end
        n_checks++;
        if (last_tw_rdata !== 32'hA5A5_0003) begin n_fail++; $display("[TB] FAIL busy_tw_data: got %h expected a5a50003", last_tw_rdata); end
        walk_busy = 1'b0;
        #1;
        n_checks++;
        if (cpu_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_release: got %b expected 1", cpu_req_ready); end
        tick();
        cpu_req_valid = 1'b0;
        walk_busy = 1'b1;
        repeat (5) tick();
        walk_busy = 1'b0;
        cpu_rsp_ready = 1'b0;
        tw_rsp_ready  = 1'b0;
        n_checks++;
        if ({wr_count - wr0, 28'h0, last_wr_addr, last_wr_data} !== {32'sd1, 32'd2, 32'hCAFE_0002}) begin
            n_fail++;
            $display("[TB] FAIL busy_tc_write: got n=%0d addr=%h data=%h expected n=1 addr=2 data=cafe0002",
                     wr_count - wr0, last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_invalid();
        logic acc; int lat; logic [DW-1:0] rd; logic err; int s0;
        s0 = wr_count + rd_count;
        cpu_txn(1'b0, 4'd9, 32'h0, acc, lat, rd, err);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("[TB] FAIL invalid_latency: got %0d expected 2", lat); end
        n_checks++;
        if ({err, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("[TB] FAIL invalid_rsp: got err=%b rdata=%h expected 1/0", err, rd); end
        n_checks++;
        if (wr_count + rd_count - s0 !== 0) begin n_fail++; $display("[TB] FAIL invalid_strobe: got %0d expected 0", wr_count + rd_count - s0); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held; logic stable_ok; logic tw_seen;
        cpu_req_we = 1'b0; cpu_req_addr = 4'd3; cpu_req_valid = 1'b1;
        cpu_rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (cpu_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_accept: got %b expected 1", cpu_req_ready); end
        tick();
        cpu_req_valid = 1'b0;
        tw_req_we = 1'b0; tw_req_addr = 4'd4; tw_req_valid = 1'b1;
        for (int i = 0; i < 20 && !cpu_rsp_valid; i++) tick();
        held = cpu_rsp_rdata;
        n_checks++;
        if ({cpu_rsp_valid, held} !== {1'b1, 32'hA5A5_0003}) begin
            n_fail++;
            $display("[TB] FAIL bp_rsp: got valid=%b rdata=%h expected 1/a5a50003", cpu_rsp_valid, held);
        end
        stable_ok = 1'b1;
        tw_seen   = tw_req_ready;
        repeat (4) begin
            tick();
            if (!cpu_rsp_valid || cpu_rsp_rdata !== held) stable_ok = 1'b0;
            if (tw_req_ready) tw_seen = 1'b1;
        end
        n_checks++;
        if (stable_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_stable: got %b expected 1", stable_ok); end
        n_checks++;
        if (tw_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_tw_waits: got %b expected 0", tw_seen); end
        cpu_rsp_ready = 1'b1;
        tick();
        cpu_rsp_ready = 1'b0;
        n_checks++;
        if ({cpu_rsp_valid, tw_req_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL bp_release: got rsp_valid=%b tw_ready=%b expected 0/1", cpu_rsp_valid, tw_req_ready);
        end
        tick();
        tw_req_valid = 1'b0;
        tw_rsp_ready = 1'b1;
        repeat (5) tick();
        tw_rsp_ready = 1'b0;
        n_checks++;
        if (last_tw_rdata !== 32'hA5A5_0004) begin n_fail++; $display("[TB] FAIL bp_tw_data: got %h expected a5a50004", last_tw_rdata); end
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = wr_count + rd_count;
        cpu_req_we = 1'b1; cpu_req_addr = 4'd1; cpu_req_wdata = 32'hDEAD_BEEF; cpu_req_valid = 1'b1;
        #1;
        n_checks++;
        if (cpu_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_accept: got %b expected 1", cpu_req_ready); end
        tick();
        cpu_req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (wr_count + rd_count - s0 !== 0) begin n_fail++; $display("[TB] FAIL midrst_strobe: got %0d expected 0", wr_count + rd_count - s0); end
        n_checks++;
        if ({cpu_req_ready, tw_req_ready, cpu_rsp_valid, tw_rsp_valid, cpu_rsp_err, tw_rsp_err,
             reg_wr_en, reg_rd_en} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL midrst_ctrl: got %b expected 00000000",
                     {cpu_req_ready, tw_req_ready, cpu_rsp_valid, tw_rsp_valid, cpu_rsp_err,
                      tw_rsp_err, reg_wr_en, reg_rd_en});
        end
        n_checks++;
        if ({cpu_rsp_rdata, tw_rsp_rdata, reg_wr_data, reg_addr} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrst_data: got %h %h %h %h expected all zero",
                     cpu_rsp_rdata, tw_rsp_rdata, reg_wr_data, reg_addr);
        end
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        cpu_rsp_ready = 1'b0;
        tw_req_valid  = 1'b0; tw_req_we  = 1'b0; tw_req_addr  = '0; tw_req_wdata  = '0;
        tw_rsp_ready  = 1'b0;
        walk_busy     = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_walk_busy();
        test_invalid();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
